// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes and FSM state encoding for the EX stage
//
// Purpose : Shared constants for ex_alu_stage and its iterative shifter.
// Contents: ALU_* 4-bit control codes, alu_state_e FSM encoding, is_shift_op helper.

package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] ctl);
    return (ctl == ALU_SLL) || (ctl == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - iterative shifter, up to SHIFT_STEP bit positions per cycle
//
// Purpose : Holds the shift register and remaining count for a multi-cycle shift.
// Ports   : clk, rst_n   clock / async active-low reset
//           start_i      load data_i/amt_i/right_i (amount must be non-zero)
//           abort_i      drop an in-progress shift (wins over start_i)
//           right_i      1 = logical right shift, 0 = left shift
//           data_i       value to shift
//           amt_i        total shift amount
//           done_o       this is the last shifting cycle; data_o holds the final value
//           data_o       value after this cycle's partial shift

module alu_shift_iter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     right_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [$clog2(XLEN)-1:0]  amt_i,
  output logic                     done_o,
  output logic [XLEN-1:0]          data_o
);

  localparam int SHW = $clog2(XLEN);
  // One extra bit so a step of XLEN positions is representable.
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  logic [XLEN-1:0] shreg_q;
  logic [SHW-1:0]  rem_q;
  logic            right_q;
  logic            busy_q;

  logic [SHW:0]    rem_ext;
  logic [SHW:0]    step_amt;
  logic [SHW:0]    rem_d;

  assign rem_ext  = {1'b0, rem_q};
  // Final step moves only what is left.
  assign step_amt = (rem_ext < STEP) ? rem_ext : STEP;
  assign rem_d    = rem_ext - step_amt;
  assign data_o   = right_q ? (shreg_q >> step_amt) : (shreg_q << step_amt);
  assign done_o   = busy_q && (rem_ext <= STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      rem_q   <= '0;
      right_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (abort_i) begin
      busy_q  <= 1'b0;
    end else if (start_i) begin
      shreg_q <= data_i;
      rem_q   <= amt_i;
      right_q <= right_i;
      busy_q  <= (amt_i != '0);
    end else if (busy_q) begin
      shreg_q <= data_o;
      rem_q   <= rem_d[SHW-1:0];
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - RISC-V EX-stage ALU with valid/ready handshake and iterative shifts
//
// Purpose : Computes add/sub/and/or/xor in one cycle and sll/srl iteratively, registering
//           result, zero flag, error flag and rd tag into the EX/MEM boundary.
// Ports   : clk, rst_n            clock / async active-low reset
//           flush                 pipeline flush, highest priority
//           in_valid/in_ready     ID/EX handshake; aluctl, op_a, op_b, in_rd
//           out_valid/out_ready   EX/MEM handshake; result, zero, out_rd, err
//           ovf                   signed add/sub overflow (only with ALU_OVF_FLAG_EN)
// Config  : ALU_OVF_FLAG_EN adds the ovf port and its overflow logic.

module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      aluctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      out_rd,
  output logic            err
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic            ovf
`endif
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [4:0]      rd_pend_q, rd_pend_d;

  logic            accept;
  logic            handoff;
  logic            shift_start;
  logic            shift_done;
  logic [XLEN-1:0] shift_res;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] alu_res;
  logic            alu_err;

  assign in_ready    = !flush && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign handoff     = out_valid_q && out_ready;
  assign shamt       = op_b[SHW-1:0];
  // A zero-amount shift completes in the single-cycle path.
  assign shift_start = accept && is_shift_op(aluctl) && (shamt != '0);

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (aluctl)
      ALU_ADD: alu_res = sum;
      ALU_SUB: alu_res = diff;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL,
      ALU_SRL: alu_res = op_a;
      default: alu_err = 1'b1;
    endcase
  end

  alu_shift_iter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (shift_start),
    .abort_i (flush),
    .right_i (aluctl == ALU_SRL),
    .data_i  (op_a),
    .amt_i   (shamt),
    .done_o  (shift_done),
    .data_o  (shift_res)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    err_d       = err_q;
    out_rd_d    = out_rd_q;
    rd_pend_d   = rd_pend_q;
    if (flush) begin
      // result/out_rd are left stale; only validity and the FSM are cleared.
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (handoff) begin
            out_valid_d = 1'b0;
          end
          if (accept) begin
            if (shift_start) begin
              state_d   = ST_BUSY;
              rd_pend_d = in_rd;
            end else begin
              out_valid_d = 1'b1;
              result_d    = alu_res;
              zero_d      = (alu_res == '0);
              err_d       = alu_err;
              out_rd_d    = in_rd;
            end
          end
        end
        ST_BUSY: begin
          if (shift_done) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
            result_d    = shift_res;
            zero_d      = (shift_res == '0);
            err_d       = 1'b0;
            out_rd_d    = rd_pend_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      out_rd_q    <= '0;
      rd_pend_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      out_rd_q    <= out_rd_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign out_rd    = out_rd_q;

`ifdef ALU_OVF_FLAG_EN
  logic ovf_q, ovf_d, alu_ovf;

  // Signed overflow: operands' signs make the true result unrepresentable.
  always_comb begin
    alu_ovf = 1'b0;
    if (aluctl == ALU_ADD) begin
      alu_ovf = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
    end else if (aluctl == ALU_SUB) begin
      alu_ovf = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (flush) begin
      ovf_d = 1'b0;
    end else if (accept && !shift_start) begin
      ovf_d = alu_ovf;
    end else if ((state_q == ST_BUSY) && shift_done) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - self-checking bench for ex_alu_stage with a behavioural model

module tb_ex_alu_stage;

  localparam int XLEN = 32;
  localparam int STEP = 4;

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_XOR = 4'b1100;
  localparam logic [3:0] C_SLL = 4'b0011;
  localparam logic [3:0] C_SRL = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, err;
  logic [3:0]  aluctl;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  in_rd, out_rd;
`ifdef ALU_OVF_FLAG_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  ex_alu_stage #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluctl    (aluctl),
    .op_a      (op_a),
    .op_b      (op_b),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .out_rd    (out_rd),
    .err       (err)
`ifdef ALU_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, written directly from the ALU definition.
  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (c)
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_AND:   return a & b;
      C_OR:    return a | b;
      C_XOR:   return a ^ b;
      C_SLL:   return a << s;
      C_SRL:   return a >> s;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [3:0] c);
    return c inside {C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_SLL, C_SRL};
  endfunction

  function automatic bit ref_ovf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (c == C_ADD)      r = longint'($signed(a)) + longint'($signed(b));
    else if (c == C_SUB) r = longint'($signed(a)) - longint'($signed(b));
    else                 return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
    if (c == C_SLL || c == C_SRL) return (int'(b[4:0]) + STEP - 1) / STEP;
    return 0;
  endfunction

  // Model state: what the output boundary must show, plus an in-flight shift.
  bit          m_valid;
  logic [31:0] m_res, p_res, r;
  bit          m_zero, m_err, m_ovf, exp_rdy;
  logic [4:0]  m_rd, p_rd;
  int          m_busy, lat;

  // Inputs change only just after posedge, so at negedge they are exactly what
  // the coming posedge will see: compare first, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 0; m_busy = 0; m_res = '0; m_zero = 0; m_err = 0; m_rd = '0; m_ovf = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_err", err, 0);
    end else begin
      exp_rdy = !flush && (m_busy == 0) && (!m_valid || out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("result", result, m_res);
        chk("zero", zero, m_zero);
        chk("err", err, m_err);
        chk("out_rd", out_rd, m_rd);
`ifdef ALU_OVF_FLAG_EN
        chk("ovf", ovf, m_ovf);
`endif
      end
      if (flush) begin
        m_valid = 0; m_busy = 0; m_ovf = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1; m_res = p_res; m_zero = (p_res == 0); m_err = 0; m_ovf = 0; m_rd = p_rd;
        end
      end else begin
        if (m_valid && out_ready) m_valid = 0;
        if (in_valid && exp_rdy) begin
          r   = ref_res(aluctl, op_a, op_b);
          lat = ref_lat(aluctl, op_b);
          if (lat == 0) begin
            m_valid = 1; m_res = r; m_zero = (r == 0); m_err = !ref_legal(aluctl);
            m_ovf = ref_ovf(aluctl, op_a, op_b); m_rd = in_rd;
          end else begin
            m_busy = lat; p_res = r; p_rd = in_rd;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int w;
    w = 0;
    aluctl = c; op_a = a; op_b = b; in_rd = rd; in_valid = 1'b1;
    #1;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", w);
    end
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] codes [8] = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_SLL, C_SRL, 4'b1111};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    aluctl = C_ADD; op_a = '0; op_b = '0; in_rd = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // add 7,5
    issue(C_ADD, 32'd7, 32'd5, 5'd1);
    chk("t1_valid", out_valid, 1);
    chk("t1_result", result, 32'd12);
    chk("t1_zero", zero, 0);
    chk("t1_err", err, 0);

    // sub wrap and zero flag
    issue(C_SUB, 32'd5, 32'd7, 5'd2);
    chk("t2_sub_wrap", result, 32'hFFFF_FFFE);
    issue(C_SUB, 32'd9, 32'd9, 5'd3);
    chk("t2_sub_zero_res", result, 32'h0);
    chk("t2_sub_zero_flag", zero, 1);

    // sll 1 by 31: 8 busy cycles, result at N+9
    issue(C_SLL, 32'd1, 32'd31, 5'd4);
    for (int i = 0; i < 8; i++) begin
      chk("t3_busy_in_ready", in_ready, 0);
      chk("t3_busy_valid", out_valid, 0);
      step();
    end
    chk("t3_sll_valid", out_valid, 1);
    chk("t3_sll_result", result, 32'h8000_0000);
    chk("t3_sll_rd", out_rd, 32'd4);
    issue(C_SRL, 32'h8000_0000, 32'd0, 5'd5);
    chk("t3_srl0_result", result, 32'h8000_0000);

    // backpressure hold, then back-to-back handoff + accept
    issue(C_XOR, 32'hF0, 32'hFF, 5'd6);
    out_ready = 1'b0;
    aluctl = C_ADD; op_a = 32'd3; op_b = 32'd4; in_rd = 5'd7; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_result", result, 32'h0F);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t4_next_result", result, 32'd7);
    chk("t4_next_rd", out_rd, 32'd7);

    // flush during srl by 20
    issue(C_SRL, 32'hFFFF_FFFF, 32'd20, 5'd8);
    step();
    step();
    flush = 1'b1;
    #1;
    chk("t5_flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("t5_flush_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_result", out_valid, 0);
    end
    issue(C_ADD, 32'd1, 32'd1, 5'd9);
    chk("t5_add_after", result, 32'd2);

    // illegal code
    issue(4'b1111, 32'd123, 32'd456, 5'd10);
    chk("t6_err", err, 1);
    chk("t6_result", result, 0);
    chk("t6_zero", zero, 1);
`ifdef ALU_OVF_FLAG_EN
    issue(C_ADD, 32'h7FFF_FFFF, 32'd1, 5'd11);
    chk("t6_ovf_add", ovf, 1);
    chk("t6_ovf_add_res", result, 32'h8000_0000);
    issue(C_SUB, 32'h8000_0000, 32'd1, 5'd12);
    chk("t6_ovf_sub", ovf, 1);
`endif

    // reset in the middle of a shift
    issue(C_SLL, 32'd3, 32'd17, 5'd13);
    step();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_result", result, 0);
    chk("t7_rst_rd", out_rd, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t7_no_partial", out_valid, 0);
    end

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      aluctl    = codes[$urandom_range(0, 7)];
      op_a      = rand_word();
      op_b      = ($urandom_range(0, 3) == 0) ? rand_word() : $urandom;
      in_rd     = 5'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
